// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform post-processing blocks:
// image geometry, memory depths and the skeleton-scan state/offset encodings.
package dt_pkg;

    localparam int IMG_W     = 128;
    localparam int DATA_W    = 8;
    localparam int WORD_W    = 16;
    localparam int RES_DEPTH = IMG_W * IMG_W;
    localparam int STI_DEPTH = RES_DEPTH / WORD_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        ACC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Neighbour fetch order within one pixel's READ phase
    typedef enum logic [2:0] {
        NBR_C = 3'd0,
        NBR_W = 3'd1,
        NBR_E = 3'd2,
        NBR_N = 3'd3,
        NBR_S = 3'd4
    } nbr_t;

endpackage

// File: rtl/dt_nbr_addr.sv
// Maps a pixel pointer and neighbour offset to a result-RAM address; neighbours
// outside the image fall back to the centre address with inImg low.
module dt_nbr_addr
    import dt_pkg::*;
#(
    parameter int IMG_W = dt_pkg::IMG_W,
    localparam int CW = $clog2(IMG_W),
    localparam int AW = 2 * CW
)(
    input  logic [AW-1:0] ptr,
    input  nbr_t          off,
    output logic [AW-1:0] addr,
    output logic          inImg
);

    logic [CW-1:0] row_s;
    logic [CW-1:0] col_s;

    assign row_s = ptr[AW-1:CW];
    assign col_s = ptr[CW-1:0];

    // Neighbour address selection with image-border clamping
    always_comb begin
        addr  = ptr;
        inImg = 1'b1;
        case (off)
            NBR_C: begin
                addr  = ptr;
                inImg = 1'b1;
            end
            NBR_W: begin
                if (col_s != CW'(0)) begin
                    addr = {row_s, col_s - CW'(1)};
                end else begin
                    inImg = 1'b0;
                end
            end
            NBR_E: begin
                if (col_s != CW'(IMG_W - 1)) begin
                    addr = {row_s, col_s + CW'(1)};
                end else begin
                    inImg = 1'b0;
                end
            end
            NBR_N: begin
                if (row_s != CW'(0)) begin
                    addr = {row_s - CW'(1), col_s};
                end else begin
                    inImg = 1'b0;
                end
            end
            NBR_S: begin
                if (row_s != CW'(IMG_W - 1)) begin
                    addr = {row_s + CW'(1), col_s};
                end else begin
                    inImg = 1'b0;
                end
            end
            default: begin
                addr  = ptr;
                inImg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dt_skeleton_extract.sv
// Scans the distance map after the DT engine finishes, marks medial-axis pixels
// into packed skeleton words and tracks the maximum distance and skeleton count.
module dt_skeleton_extract
    import dt_pkg::*;
#(
    parameter int IMG_W  = dt_pkg::IMG_W,
    parameter int DATA_W = dt_pkg::DATA_W,
    parameter int WORD_W = dt_pkg::WORD_W,
    localparam int CW = $clog2(IMG_W),
    localparam int AW = 2 * CW,
    localparam int GW = $clog2(WORD_W),
    localparam int SW = AW - GW,
    localparam int NW = AW + 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              res_rd,
    output logic [AW-1:0]     res_addr,
    input  logic [DATA_W-1:0] res_di,
    output logic              skel_wr,
    output logic [SW-1:0]     skel_addr,
    output logic [WORD_W-1:0] skel_do,
    output logic [DATA_W-1:0] max_dist,
    output logic [NW-1:0]     skel_count
);

    state_t              state_r, nextState_s;
    nbr_t                off_r, nextOff_s;
    logic [AW-1:0]       ptr_r, nextPtr_s;
    logic                clearStats_s;
    logic [DATA_W-1:0]   valC_r, valW_r, valE_r, valN_r, valS_r;
    logic [DATA_W-1:0]   capVal_s;
    logic [WORD_W-1:0]   shift_r;
    logic                skelBit_s;
    logic                groupEnd_s;
    logic                lastPix_s;
    logic [AW-1:0]       nbrAddr_s;
    logic                nbrIn_s;

    logic                busy_r, done_r, resRd_r, skelWr_r;
    logic [AW-1:0]       resAddr_r;
    logic [SW-1:0]       skelAddr_r;
    logic [WORD_W-1:0]   skelDo_r;
    logic [DATA_W-1:0]   maxDist_r;
    logic [NW-1:0]       skelCount_r;

    assign busy       = busy_r;
    assign done       = done_r;
    assign res_rd     = resRd_r;
    assign res_addr   = resAddr_r;
    assign skel_wr    = skelWr_r;
    assign skel_addr  = skelAddr_r;
    assign skel_do    = skelDo_r;
    assign max_dist   = maxDist_r;
    assign skel_count = skelCount_r;

    assign skelBit_s  = (valC_r != DATA_W'(0)) && (valC_r >= valW_r) && (valC_r >= valE_r)
                        && (valC_r >= valN_r) && (valC_r >= valS_r);
    assign groupEnd_s = &ptr_r[GW-1:0];
    assign lastPix_s  = &ptr_r;
    // Out-of-image neighbours were not strobed, so their value reads as zero
    assign capVal_s   = resRd_r ? res_di : DATA_W'(0);

    // Address generator runs one cycle ahead so the RAM outputs are registered
    dt_nbr_addr #(.IMG_W(IMG_W)) uNbrAddr (
        .ptr   (nextPtr_s),
        .off   (nextOff_s),
        .addr  (nbrAddr_s),
        .inImg (nbrIn_s)
    );

    // Next-state, next-offset and next-pointer logic
    always_comb begin
        nextState_s  = state_r;
        nextOff_s    = off_r;
        nextPtr_s    = ptr_r;
        clearStats_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    nextState_s  = READ;
                    nextOff_s    = NBR_C;
                    nextPtr_s    = AW'(0);
                    clearStats_s = 1'b1;
                end else begin
                    nextState_s = state_r;
                end
            end
            READ: begin
                if (off_r == NBR_S) begin
                    nextState_s = ACC;
                    nextOff_s   = NBR_C;
                end else begin
                    nextOff_s = nbr_t'(off_r + 3'd1);
                end
            end
            ACC: begin
                if (groupEnd_s) begin
                    nextState_s = WRITE;
                end else begin
                    nextState_s = READ;
                    nextPtr_s   = ptr_r + AW'(1);
                end
            end
            WRITE: begin
                if (lastPix_s) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = READ;
                    nextPtr_s   = ptr_r + AW'(1);
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // FSM state, offset and pixel pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            off_r   <= NBR_C;
            ptr_r   <= AW'(0);
        end else begin
            state_r <= nextState_s;
            off_r   <= nextOff_s;
            ptr_r   <= nextPtr_s;
        end
    end

    // Latch the neighbour value fetched in each READ cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valC_r <= DATA_W'(0);
            valW_r <= DATA_W'(0);
            valE_r <= DATA_W'(0);
            valN_r <= DATA_W'(0);
            valS_r <= DATA_W'(0);
        end else if (state_r == READ) begin
            case (off_r)
                NBR_C:   valC_r <= capVal_s;
                NBR_W:   valW_r <= capVal_s;
                NBR_E:   valE_r <= capVal_s;
                NBR_N:   valN_r <= capVal_s;
                NBR_S:   valS_r <= capVal_s;
                default: valC_r <= valC_r;
            endcase
        end
    end

    // Skeleton shift register and running statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r     <= WORD_W'(0);
            maxDist_r   <= DATA_W'(0);
            skelCount_r <= NW'(0);
        end else if (clearStats_s) begin
            shift_r     <= WORD_W'(0);
            maxDist_r   <= DATA_W'(0);
            skelCount_r <= NW'(0);
        end else if (state_r == ACC) begin
            shift_r     <= {shift_r[WORD_W-2:0], skelBit_s};
            skelCount_r <= skelCount_r + NW'(skelBit_s);
            if (valC_r > maxDist_r) begin
                maxDist_r <= valC_r;
            end
        end
    end

    // Registered status, RAM-read and RAM-write outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            resRd_r    <= 1'b0;
            resAddr_r  <= AW'(0);
            skelWr_r   <= 1'b0;
            skelAddr_r <= SW'(0);
            skelDo_r   <= WORD_W'(0);
        end else begin
            busy_r   <= (nextState_s == READ) || (nextState_s == ACC) || (nextState_s == WRITE);
            done_r   <= (state_r == DONE) && (nextState_s == DONE);
            resRd_r  <= (nextState_s == READ) && nbrIn_s;
            skelWr_r <= (nextState_s == WRITE);
            if (nextState_s == READ) begin
                resAddr_r <= nbrAddr_s;
            end
            // The word leaving ACC must already contain the group's last bit
            if ((state_r == ACC) && (nextState_s == WRITE)) begin
                skelDo_r   <= {shift_r[WORD_W-2:0], skelBit_s};
                skelAddr_r <= ptr_r[AW-1:GW];
            end
        end
    end

endmodule
